// File: rtl/bp_me_burst_arbiter_n.sv
// N-to-1 round-robin arbiter for BedRock header+data burst streams.
// A grant is held for the whole message; over-length bursts raise a sticky error.
module bp_me_burst_arbiter_n
  #(parameter int num_chan_p     = 4
  , parameter int header_width_p = 64
  , parameter int data_width_p   = 64
  , parameter int max_beats_p    = 8
  , localparam int lg_num_chan_lp    = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
  , localparam int beat_cnt_width_lp = ((max_beats_p + 1) > 1) ? $clog2(max_beats_p + 1) : 1
  )
  (input  logic                                 clk_i
  , input  logic                                reset_i
  , input  logic [num_chan_p*header_width_p-1:0] header_i
  , input  logic [num_chan_p-1:0]               header_has_data_i
  , input  logic [num_chan_p-1:0]               header_v_i
  , output logic [num_chan_p-1:0]               header_ready_and_o
  , input  logic [num_chan_p*data_width_p-1:0]  data_i
  , input  logic [num_chan_p-1:0]               data_last_i
  , input  logic [num_chan_p-1:0]               data_v_i
  , output logic [num_chan_p-1:0]               data_ready_and_o
  , output logic [header_width_p-1:0]           header_o
  , output logic                                header_v_o
  , input  logic                                header_ready_and_i
  , output logic [data_width_p-1:0]             data_o
  , output logic                                data_last_o
  , output logic                                data_v_o
  , input  logic                                data_ready_and_i
  , output logic [num_chan_p-1:0]               grant_o
  , output logic                                error_o
  );

  typedef enum logic [1:0] {e_idle = 2'd0, e_header = 2'd1, e_data = 2'd2} state_e;

  localparam logic [beat_cnt_width_lp-1:0] max_cnt_lp  = beat_cnt_width_lp'(max_beats_p);
  localparam logic [beat_cnt_width_lp-1:0] warn_cnt_lp = beat_cnt_width_lp'(max_beats_p - 1);
  localparam logic [lg_num_chan_lp-1:0]    top_chan_lp = lg_num_chan_lp'(num_chan_p - 1);

  state_e                       state_r, state_n;
  logic [lg_num_chan_lp-1:0]    grant_r, grant_n;
  logic [lg_num_chan_lp-1:0]    last_r, last_n;
  logic [beat_cnt_width_lp-1:0] beat_cnt_r, beat_cnt_n;
  logic                         error_r, error_n;

  // First requester after the previously served channel, wrapping around.
  function automatic logic [lg_num_chan_lp-1:0] rr_pick
    (input logic [num_chan_p-1:0] req, input logic [lg_num_chan_lp-1:0] last);
    logic [lg_num_chan_lp-1:0] pick;
    logic found;
    int   idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= num_chan_p; i++) begin
      idx = (int'(last) + i) % num_chan_p;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = lg_num_chan_lp'(idx);
      end
    end
    return pick;
  endfunction

  // Next-state logic and the pass-through mux from the locked channel.
  always_comb begin
    state_n            = state_r;
    grant_n            = grant_r;
    last_n             = last_r;
    beat_cnt_n         = beat_cnt_r;
    error_n            = error_r;
    header_o           = '0;
    header_v_o         = 1'b0;
    header_ready_and_o = '0;
    data_o             = '0;
    data_last_o        = 1'b0;
    data_v_o           = 1'b0;
    data_ready_and_o   = '0;
    grant_o            = '0;
    case (state_r)
      e_idle: begin
        if (|header_v_i) begin
          grant_n = rr_pick(header_v_i, last_r);
          state_n = e_header;
        end else begin
          state_n = e_idle;
        end
      end
      e_header: begin
        grant_o[grant_r]            = 1'b1;
        header_o                    = header_i[grant_r*header_width_p +: header_width_p];
        header_v_o                  = header_v_i[grant_r];
        header_ready_and_o[grant_r] = header_ready_and_i;
        if (header_v_i[grant_r] && header_ready_and_i) begin
          if (header_has_data_i[grant_r]) begin
            beat_cnt_n = '0;
            state_n    = e_data;
          end else begin
            last_n  = grant_r;
            state_n = e_idle;
          end
        end else begin
          state_n = e_header;
        end
      end
      e_data: begin
        grant_o[grant_r]          = 1'b1;
        data_o                    = data_i[grant_r*data_width_p +: data_width_p];
        data_last_o               = data_last_i[grant_r];
        data_v_o                  = data_v_i[grant_r];
        data_ready_and_o[grant_r] = data_ready_and_i;
        if (data_v_i[grant_r] && data_ready_and_i) begin
          // The beat past the legal maximum is still forwarded; only the flag records it.
          if (!data_last_i[grant_r] && (beat_cnt_r == warn_cnt_lp)) begin
            error_n = 1'b1;
          end else begin
            error_n = error_r;
          end
          if (beat_cnt_r != max_cnt_lp) begin
            beat_cnt_n = beat_cnt_r + beat_cnt_width_lp'(1);
          end else begin
            beat_cnt_n = beat_cnt_r;
          end
          if (data_last_i[grant_r]) begin
            last_n  = grant_r;
            state_n = e_idle;
          end else begin
            state_n = e_data;
          end
        end else begin
          state_n = e_data;
        end
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

  // State registers; last_r resets to the top channel so channel 0 wins first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      grant_r    <= '0;
      last_r     <= top_chan_lp;
      beat_cnt_r <= '0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      grant_r    <= grant_n;
      last_r     <= last_n;
      beat_cnt_r <= beat_cnt_n;
      error_r    <= error_n;
    end
  end

  assign error_o = error_r;

endmodule

// File: tb/tb_bp_me_burst_arbiter_n.sv
// Scoreboard bench for bp_me_burst_arbiter_n: per-channel sources feed the DUT,
// expected headers/beats (with owning channel) are queued and checked at the sink.
module tb_bp_me_burst_arbiter_n;
  localparam int nc = 4;
  localparam int hw = 64;
  localparam int dw = 64;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [nc*hw-1:0]  header_i;
  logic [nc-1:0]     header_has_data_i, header_v_i, header_ready_and_o;
  logic [nc*dw-1:0]  data_i;
  logic [nc-1:0]     data_last_i, data_v_i, data_ready_and_o;
  logic [hw-1:0]     header_o;
  logic              header_v_o, header_ready_and_i;
  logic [dw-1:0]     data_o;
  logic              data_last_o, data_v_o, data_ready_and_i;
  logic [nc-1:0]     grant_o;
  logic              error_o;

  bp_me_burst_arbiter_n #(.num_chan_p(nc), .header_width_p(hw), .data_width_p(dw), .max_beats_p(8)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .header_i(header_i), .header_has_data_i(header_has_data_i), .header_v_i(header_v_i),
    .header_ready_and_o(header_ready_and_o),
    .data_i(data_i), .data_last_i(data_last_i), .data_v_i(data_v_i), .data_ready_and_o(data_ready_and_o),
    .header_o(header_o), .header_v_o(header_v_o), .header_ready_and_i(header_ready_and_i),
    .data_o(data_o), .data_last_o(data_last_o), .data_v_o(data_v_o), .data_ready_and_i(data_ready_and_i),
    .grant_o(grant_o), .error_o(error_o));

  always #5 clk = ~clk;

  typedef struct {
    bit          is_hdr;
    logic [63:0] val;
    bit          last;
    int          ch;
  } exp_t;

  exp_t        sb[$];
  bit          hv[nc];
  bit          has[nc];
  logic [63:0] hdr[nc];
  logic [63:0] dq[nc][$];
  int          vectors = 0;
  int          miscompares = 0;
  int          dhs = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < nc; c++) begin
      header_i[c*hw +: hw]  = hdr[c];
      header_v_i[c]         = hv[c];
      header_has_data_i[c]  = has[c];
      data_v_i[c]           = (dq[c].size() != 0);
      data_i[c*dw +: dw]    = (dq[c].size() != 0) ? dq[c][0] : 64'h0;
      data_last_i[c]        = (dq[c].size() == 1);
    end
  endtask

  task automatic clear_sources();
    for (int c = 0; c < nc; c++) begin
      hv[c]  = 1'b0;
      has[c] = 1'b0;
      hdr[c] = 64'h0;
      dq[c].delete();
    end
    sb.delete();
    drive();
  endtask

  // Queue a message on channel ch; data beats are presented immediately (early).
  task automatic submit(input int ch, input logic [63:0] h, input int nbeats);
    exp_t e;
    logic [63:0] v;
    hv[ch]  = 1'b1;
    hdr[ch] = h;
    has[ch] = (nbeats > 0);
    e.is_hdr = 1'b1; e.val = h; e.last = 1'b0; e.ch = ch;
    sb.push_back(e);
    for (int b = 0; b < nbeats; b++) begin
      v = {h[31:0], 32'(b)};
      dq[ch].push_back(v);
      e.is_hdr = 1'b0; e.val = v; e.last = (b == nbeats - 1); e.ch = ch;
      sb.push_back(e);
    end
    drive();
  endtask

  task automatic sb_pop(input bit is_hdr, input logic [63:0] val, input bit last);
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_unexpected", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check_val("kind", 64'(is_hdr), 64'(e.is_hdr));
      check_val(is_hdr ? "header_o" : "data_o", val, e.val);
      check_val("grant_o", 64'(grant_o), 64'(4'b0001 << e.ch));
      if (!is_hdr) check_val("data_last_o", 64'(last), 64'(e.last));
    end
  endtask

  // One clock: score sink handshakes at negedge, retire source handshakes after posedge.
  task automatic step();
    logic [nc-1:0] hh, dh;
    @(negedge clk);
    hh = header_v_i & header_ready_and_o;
    dh = data_v_i & data_ready_and_o;
    if (header_v_o && header_ready_and_i) sb_pop(1'b1, header_o, 1'b0);
    if (data_v_o && data_ready_and_i) begin
      dhs++;
      sb_pop(1'b0, data_o, data_last_o);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < nc; c++) begin
      if (hh[c]) hv[c] = 1'b0;
      if (dh[c]) void'(dq[c].pop_front());
    end
    drive();
    #1;
  endtask

  task automatic drain(input int maxc, output int n);
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    check_val("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    clear_sources();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_outs"},
              64'({header_v_o, data_v_o, data_last_o, error_o, grant_o, header_ready_and_o, data_ready_and_o}),
              64'd0);
    check_val({tag, "_payload"}, header_o | data_o, 64'd0);
  endtask

  int n;
  int d0;
  bit seen7, seen8;

  initial begin
    header_ready_and_i = 1'b1;
    data_ready_and_i   = 1'b1;
    reset_i            = 1'b1;
    header_i = '0; header_has_data_i = '0; header_v_i = '0;
    data_i = '0; data_last_i = '0; data_v_i = '0;
    do_reset();
    check_idle_outputs("reset");

    // 1: single header-only message, 1-cycle arbitration latency
    submit(0, 64'hA000_0000_0000_00A0, 0);
    check_val("t1_hv_lat0", 64'(header_v_o), 64'd0);
    step();
    check_val("t1_hv_lat1", 64'(header_v_o), 64'd1);
    check_val("t1_grant", 64'(grant_o), 64'h1);
    step();
    check_val("t1_grant_idle", 64'(grant_o), 64'h0);
    check_val("t1_error", 64'(error_o), 64'd0);
    check_val("t1_sb", 64'(sb.size()), 64'd0);

    // 2: all four at once, round-robin 0..3 at two cycles each, then again
    do_reset();
    for (int c = 0; c < nc; c++) submit(c, 64'hB000_0000_0000_00B0 + 64'(c), 0);
    drain(40, n);
    check_val("t2_cycles", 64'(n), 64'd8);
    for (int c = 0; c < nc; c++) submit(c, 64'hB100_0000_0000_00B0 + 64'(c), 0);
    drain(40, n);
    check_val("t2_cycles_again", 64'(n), 64'd8);

    // 3: channel 2 4-beat burst, channel 1 stalls until last, sink data ready toggles
    do_reset();
    submit(2, 64'hC000_0000_0000_00C2, 4);
    step();
    check_val("t3_no_early_data", 64'({data_v_o, data_ready_and_o}), 64'd0);
    step();
    submit(1, 64'hC000_0000_0000_00C1, 0);
    n = 0;
    while (dq[2].size() != 0 && n < 20) begin
      check_val("t3_ch1_stall", 64'(header_ready_and_o[1]), 64'd0);
      data_ready_and_i = (n % 2 == 0);
      step();
      n++;
    end
    check_val("t3_burst_cycles", 64'(n), 64'd7);
    data_ready_and_i = 1'b1;
    drain(20, n);

    // 4: nine beats against a max of eight -> sticky error on the 8th handshake
    do_reset();
    d0 = dhs;
    seen7 = 1'b0;
    seen8 = 1'b0;
    submit(0, 64'hD000_0000_0000_00D0, 9);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
      if (dhs - d0 == 7 && !seen7) begin
        seen7 = 1'b1;
        check_val("t4_err_at7", 64'(error_o), 64'd0);
      end
      if (dhs - d0 == 8 && !seen8) begin
        seen8 = 1'b1;
        check_val("t4_err_at8", 64'(error_o), 64'd1);
      end
    end
    check_val("t4_beats", 64'(dhs - d0), 64'd9);
    repeat (3) step();
    check_val("t4_err_sticky", 64'(error_o), 64'd1);
    do_reset();
    check_val("t4_err_cleared", 64'(error_o), 64'd0);

    // 5: sink header stall holds grant and header against a higher-priority request
    header_ready_and_i = 1'b0;
    submit(2, 64'hE000_0000_0000_00E2, 0);
    step();
    submit(0, 64'hE000_0000_0000_00E0, 0);
    for (int k = 0; k < 5; k++) begin
      check_val("t5_header_hold", header_o, 64'hE000_0000_0000_00E2);
      check_val("t5_grant_hold", 64'(grant_o), 64'h4);
      step();
    end
    header_ready_and_i = 1'b1;
    drain(20, n);

    // 6: reset during beat 2 of a 4-beat burst aborts; channel 0 wins afterwards
    do_reset();
    d0 = dhs;
    submit(1, 64'hF000_0000_0000_00F1, 4);
    n = 0;
    while (dhs - d0 < 1 && n < 10) begin
      step();
      n++;
    end
    check_val("t6_beat1", 64'(dhs - d0), 64'd1);
    reset_i            = 1'b1;
    data_ready_and_i   = 1'b0;
    header_ready_and_i = 1'b0;
    step();
    check_idle_outputs("t6_abort");
    clear_sources();
    reset_i            = 1'b0;
    data_ready_and_i   = 1'b1;
    header_ready_and_i = 1'b1;
    submit(0, 64'hF000_0000_0000_00F0, 0);
    submit(3, 64'hF000_0000_0000_00F3, 0);
    drain(20, n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_me_burst_arbiter_n.md
Name: bp_me_burst_arbiter_n

Overview:
- Parametrised N-to-1 arbiter for BedRock burst streams: per channel, one header channel plus one data channel, both ready&valid.
- Merges num_chan_p independent burst sources onto one burst sink, e.g. multiple LCE request ports into one CCE request port, or multiple CCE mem_cmd ports into one memory port.
- Round-robin fairness; a grant is locked for the whole message (header plus all data beats), so beats from different sources never interleave.
- Adds protocol checking: a sticky over-length burst error.

Parameters:
- num_chan_p, 4, number of input burst channels (>=1)
- header_width_p, 64, message header width in bits
- data_width_p, 64, data beat width in bits
- max_beats_p, 8, maximum legal data beats per message (>=1)
- lg_num_chan_lp, `BSG_SAFE_CLOG2(num_chan_p), grant index width (localparam)
- beat_cnt_width_lp, `BSG_SAFE_CLOG2(max_beats_p+1), beat counter width (localparam)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- header_i  in  num_chan_p*header_width_p  per-channel headers
- header_has_data_i  in  num_chan_p  per-channel flag, qualified by header_v_i: 1 = data beats follow this header
- header_v_i  in  num_chan_p  per-channel header valid
- header_ready_and_o  out  num_chan_p  per-channel header ready
- data_i  in  num_chan_p*data_width_p  per-channel data beats
- data_last_i  in  num_chan_p  per-channel last-beat flag
- data_v_i  in  num_chan_p  per-channel data valid
- data_ready_and_o  out  num_chan_p  per-channel data ready
- header_o  out  header_width_p  merged header
- header_v_o  out  1  merged header valid
- header_ready_and_i  in  1  sink header ready
- data_o  out  data_width_p  merged data beat
- data_last_o  out  1  merged last-beat flag
- data_v_o  out  1  merged data valid
- data_ready_and_i  in  1  sink data ready
- grant_o  out  num_chan_p  one-hot currently locked channel; 0 when idle
- error_o  out  1  sticky over-length burst error

Behaviour:
- Handshake on any channel = v & ready_and in the same cycle. Sources hold v and payload stable until that handshake.
- State machine, states e_idle, e_header, e_data.
- e_idle:
  - header_v_o = 0, data_v_o = 0, all ready_and_o = 0.
  - If any header_v_i is set, register grant_r = first set bit in round-robin order starting at last_r+1 (mod num_chan_p), then go to e_header.
  - Result: 1-cycle arbitration latency from header_v_i to header_v_o.
- e_header:
  - header_o = header_i[grant_r]; header_v_o = header_v_i[grant_r].
  - header_ready_and_o[grant_r] = header_ready_and_i; all other bits 0.
  - On handshake with has_data = 1: clear beat_cnt_r and go to e_data.
  - On handshake with has_data = 0: last_r <= grant_r, go to e_idle.
- e_data:
  - data_o, data_last_o and data_v_o are muxed from grant_r; data_ready_and_o[grant_r] = data_ready_and_i; all other bits 0.
  - Each handshake increments beat_cnt_r.
  - Handshake with data_last_i[grant_r] = 1: last_r <= grant_r, go to e_idle.
- Header and data paths are combinational pass-through from the locked channel; there is no buffering.
- Data is never accepted in e_idle or e_header, even if data_v_i is already high. Data on the granted channel may be presented early; it waits until e_data.
- Headers from non-granted channels stall (ready = 0) for the full duration of the locked message.
- Grant does not change while header_v_o or data_v_o is asserted without a handshake, so the output obeys ready&valid stability.
- Error check: a data handshake without last while beat_cnt_r == max_beats_p-1 sets error_o. The beat is still forwarded and the burst continues until last. error_o clears only on reset. beat_cnt_r saturates at max_beats_p.
- num_chan_p = 1: the grant is always 0; the same FSM and latencies apply.
- Reset values:
  - state = e_idle, grant_r = 0, last_r = num_chan_p-1 (so channel 0 wins first), beat_cnt_r = 0, error_o = 0.
  - All v_o, all ready_and_o and grant_o are 0.
- Reset mid-message aborts the message immediately. The remaining beats are the source's responsibility; the arbiter restarts in e_idle.
- grant_o = one-hot(grant_r) in e_header and e_data, 0 in e_idle.

Test Plan:
1. Reset, then channel 0 header (no data) with sink ready -> header_v_o rises 1 cycle after header_v_i; handshake next cycle; grant_o = 4'b0001 for 1 cycle; error_o = 0.
2. All 4 channels raise header-only requests simultaneously, sink always ready -> grant order 0,1,2,3; each message takes 2 cycles; then 0 again if resubmitted.
3. Channel 2 header with has_data and 4 beats, last on beat 4; channel 1 requests mid-burst; sink data_ready toggles 1,0,1,0 -> data_o beats in order, no interleave; channel 1 header_ready_and_o stays 0 until channel 2's last handshake; channel 1 is granted next.
4. max_beats_p = 8, source sends 9 beats with last on the 9th -> error_o rises on the 8th (non-last) handshake; all 9 beats forwarded; error_o remains 1 until reset.
5. Sink header_ready_and_i held 0 for 5 cycles while a higher-priority channel raises header_v_i -> header_o and grant_o unchanged for those 5 cycles; original header delivered.
6. reset_i asserted during beat 2 of a 4-beat burst -> next cycle all outputs 0, state e_idle; a new request afterwards grants channel 0 first.
